// File: rtl/sysa_pkg.sv
// Shared definitions for the systolic-array activation feeder.
//   state_t   : feeder FSM state encoding
//   drain_len : number of zero-injection beats needed to flush an N-lane skew
package sysa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// One lane of the input skew: a DEPTH-stage shift register that only moves
// when en is high. DEPTH=0 is a plain wire so lane 0 needs no special case
// at the instantiation site.
//   clk, rst : clock, async active-low reset
//   en       : shift enable (array advance)
//   d, q     : lane byte in / delayed lane byte out
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, en};
            assign q = d;
        end else begin : g_sr
            logic [DW-1:0] sr_q [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
                end else if (en) begin
                    sr_q[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
                end
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sysa_feeder.sv
// Activation feeder for an N x N systolic array: accepts rows over a
// valid/ready handshake, skews lane k by k advance cycles and presents the
// result on the array's left edge, then flushes the skew with zero rows.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; start latches num_rows
//   FEED  | accepting rows; act_valid=0 stalls the whole pipe
//   DRAIN | 2*N-1 unconditional advances injecting zero bytes
//   FIN   | last beat on arr_in; raises done for the following cycle
//
// Ports:
//   clk, rst            : clock, async active-low reset
//   start, num_rows     : transfer request and row count (IDLE only)
//   act_valid/act_ready : row handshake, act_data lane k = [DW*k +: DW]
//   arr_en, arr_in      : registered advance enable and skewed row
//   busy, done          : transfer in progress / one-cycle completion
module sysa_feeder
    import sysa_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      num_rows,
    input  logic            act_valid,
    output logic            act_ready,
    input  logic [DW*N-1:0] act_data,
    output logic            arr_en,
    output logic [DW*N-1:0] arr_in,
    output logic            busy,
    output logic            done
);

    localparam int             DCW        = $clog2(2 * N);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_len(N) - 1);

    state_t            state_q;
    logic [7:0]        row_cnt_q;
    logic [DCW-1:0]    drain_cnt_q;
    logic              arr_en_q;
    logic              done_q;
    logic [DW*N-1:0]   arr_in_q;
    logic [DW*N-1:0]   arr_in_d;
    logic [DW*N-1:0]   lane_in_d;
    logic              accept;
    logic              advance;

    assign act_ready = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign accept    = act_ready & act_valid;
    // DRAIN never stalls, so every DRAIN cycle is an advance.
    assign advance   = accept | (state_q == DRAIN);
    assign lane_in_d = (state_q == FEED) ? act_data : '0;

    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            skew_line #(
                .DEPTH (k),
                .DW    (DW)
            ) u_skew (
                .clk (clk),
                .rst (rst),
                .en  (advance),
                .d   (lane_in_d[DW*k +: DW]),
                .q   (arr_in_d[DW*k +: DW])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            arr_en_q    <= 1'b0;
            done_q      <= 1'b0;
            arr_in_q    <= '0;
        end else begin
            arr_en_q <= advance;
            done_q   <= 1'b0;
            if (advance) arr_in_q <= arr_in_d;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_cnt_q <= num_rows;
                        state_q   <= (num_rows == 8'd0) ? FIN : FEED;
                    end
                end
                FEED: begin
                    if (accept) begin
                        row_cnt_q <= row_cnt_q - 8'd1;
                        // Leave before the counter could reach zero, so it never wraps.
                        if (row_cnt_q == 8'd1) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LAST;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) state_q <= FIN;
                    else                   drain_cnt_q <= drain_cnt_q - DCW'(1);
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arr_en = arr_en_q;
    assign arr_in = arr_in_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sysa_feeder.sv
module tb_sysa_feeder;

    localparam int N  = 3;
    localparam int DW = 8;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            start     = 1'b0;
    logic [7:0]      num_rows  = 8'd0;
    logic            act_valid = 1'b0;
    logic            act_ready;
    logic [DW*N-1:0] act_data  = '0;
    logic            arr_en;
    logic [DW*N-1:0] arr_in;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    sysa_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .act_data  (act_data),
        .arr_en    (arr_en),
        .arr_in    (arr_in),
        .busy      (busy),
        .done      (done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [23:0] rows [3] = '{24'h030201, 24'h060504, 24'h090807};
    logic [23:0] exp1 [$] = {24'h000001, 24'h000200, 24'h030000,
                             24'h000000, 24'h000000, 24'h000000};
    logic [23:0] exp3 [$] = {24'h000001, 24'h000204, 24'h030507, 24'h060800,
                             24'h090000, 24'h000000, 24'h000000, 24'h000000};

    logic [23:0] beats [$];
    int acc_cnt, done_cnt, done_cyc, first_beat_cyc, last_beat_cyc;
    int busy_cnt, ready_cnt, busy_after, frozen_bad;

    // Called on a falling edge; drives start at once and records outputs
    // at every following falling edge until three cycles past done.
    task automatic run_xfer(input logic [7:0] nr, input int stall_cycles, input int start_again_cyc);
        int idx = 0;
        int stall_left = 0;
        beats.delete();
        acc_cnt = 0; done_cnt = 0; done_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
        busy_cnt = 0; ready_cnt = 0; busy_after = 0; frozen_bad = 0;
        start     = 1'b1;
        num_rows  = nr;
        act_valid = 1'b1;
        act_data  = (nr != 0) ? rows[0] : 24'hEEEEEE;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = (cyc == start_again_cyc);
            if (start) num_rows = 8'd2;
            if (arr_en) begin
                beats.push_back(arr_in);
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end else if (beats.size() > 0 && arr_in !== beats[$]) begin
                frozen_bad++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) begin busy_cnt++; if (done_cnt > 0) busy_after++; end
            if (act_ready) ready_cnt++;
            act_valid = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            act_data = (idx < int'(nr)) ? rows[idx] : 24'hEEEEEE;
            if (act_ready && act_valid) begin
                acc_cnt++;
                idx++;
                if (acc_cnt == 1) stall_left = stall_cycles;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        start     = 1'b0;
        act_valid = 1'b0;
    endtask

    task automatic check_seq(input string tag, input logic [23:0] exp [$]);
        chk({tag, "_nbeats"}, 32'(beats.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < beats.size()) chk($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp[i]));
    endtask

    task automatic check_one_row(input string tag);
        check_seq(tag, exp1);
        chk({tag, "_accepts"},   32'(acc_cnt), 32'd1);
        chk({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
        chk({tag, "_done_cyc"},  32'(done_cyc), 32'd8);
        chk({tag, "_done_lag"},  32'(done_cyc - last_beat_cyc), 32'd1);
        chk({tag, "_busy_cyc"},  32'(busy_cnt), 32'd7);
    endtask

    initial begin
        #2 rst = 1'b0;
        #20;
        chk("rst_ctrl",   32'({act_ready, arr_en, busy, done}), 32'd0);
        chk("rst_arr_in", 32'(arr_in), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single row, start honoured on the first edge after reset release
        run_xfer(8'd1, 0, 0);
        check_one_row("one_row");

        // three rows back to back
        run_xfer(8'd3, 0, 0);
        check_seq("three_rows", exp3);
        chk("three_accepts", 32'(acc_cnt), 32'd3);
        chk("three_done_cnt", 32'(done_cnt), 32'd1);
        chk("three_done_lag", 32'(done_cyc - last_beat_cyc), 32'd1);
        chk("three_en_gaps", 32'(last_beat_cyc - first_beat_cyc + 1 - beats.size()), 32'd0);

        // two-cycle stall after the first accept
        run_xfer(8'd3, 2, 0);
        check_seq("stall", exp3);
        chk("stall_accepts", 32'(acc_cnt), 32'd3);
        chk("stall_en_gaps", 32'(last_beat_cyc - first_beat_cyc + 1 - beats.size()), 32'd2);
        chk("stall_frozen", 32'(frozen_bad), 32'd0);
        chk("stall_done_lag", 32'(done_cyc - last_beat_cyc), 32'd1);

        // zero rows
        run_xfer(8'd0, 0, 0);
        chk("zero_nbeats", 32'(beats.size()), 32'd0);
        chk("zero_ready", 32'(ready_cnt), 32'd0);
        chk("zero_done_cyc", 32'(done_cyc), 32'd2);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);
        chk("zero_busy_cyc", 32'(busy_cnt), 32'd1);

        // reset in the middle of FEED after two accepted rows
        start = 1'b1; num_rows = 8'd3; act_valid = 1'b1; act_data = rows[0];
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        act_data = rows[1];
        @(negedge clk);
        act_valid = 1'b0;
        chk("mid_pre_ctrl", 32'({act_ready, arr_en, busy}), 32'h7);
        chk("mid_pre_arr_in", 32'(arr_in), 32'h000204);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({act_ready, arr_en, busy, done}), 32'd0);
        chk("mid_rst_arr_in", 32'(arr_in), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_xfer(8'd1, 0, 0);
        check_one_row("after_rst");

        // start pulsed during DRAIN must be ignored
        run_xfer(8'd3, 0, 5);
        check_seq("drain_start", exp3);
        chk("drain_start_done_cnt", 32'(done_cnt), 32'd1);
        chk("drain_start_busy_after", 32'(busy_after), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sysa_feeder.md
SYSA_FEEDER -- requirements
Module: sysa_feeder

Interface
REQ-001 SHALL have parameter N, default 3, meaning systolic array dimension (lanes).
REQ-002 SHALL have parameter DW, default 8, meaning activation byte width per lane.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a matrix transfer.
REQ-006 SHALL have port num_rows  input  8  number of activation rows in the transfer, sampled on an accepted start.
REQ-007 SHALL have port act_valid  input  1  act_data holds a valid row.
REQ-008 SHALL have port act_ready  output  1  feeder accepts a row this cycle.
REQ-009 SHALL have port act_data  input  DW*N  one row; lane k is bits [DW*k +: DW].
REQ-010 SHALL have port arr_en  output  1  array advance enable; drives the array en.
REQ-011 SHALL have port arr_in  output  DW*N  skewed row to the array left edge; lane k is bits [DW*k +: DW].
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the transfer completes.

Function
REQ-014 SHALL implement an FSM with states IDLE, FEED, DRAIN, FIN.
REQ-015 In IDLE, start=1 SHALL latch num_rows into a row counter and go to FEED; if num_rows=0, it SHALL go directly to FIN.
REQ-016 start SHALL be ignored in all states other than IDLE.
REQ-017 act_ready SHALL be 1 only in FEED; it is combinational from state only, not from act_valid.
REQ-018 A row SHALL be accepted on a cycle with act_valid=1 and act_ready=1; that cycle is an advance cycle.
REQ-019 In FEED, a cycle with act_valid=0 SHALL be a stall: arr_en=0, arr_in and all skew registers held, and the counters unchanged.
REQ-020 Lane k SHALL pass through a k-stage skew delay that shifts only on advance cycles.
REQ-021 Row r, lane k SHALL appear on arr_in lane k registered after the (r+k+1)-th advance cycle of the transfer.
REQ-022 arr_en SHALL be registered and SHALL be 1 exactly in the cycle after each advance cycle, aligned with the new arr_in.
REQ-023 After the num_rows-th accept, the FSM SHALL enter DRAIN.
REQ-024 DRAIN SHALL run 2*N-1 advance cycles that inject zero bytes on all lanes, and SHALL never stall.
REQ-025 After the last DRAIN cycle, the FSM SHALL enter FIN; FIN SHALL assert done for one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in FEED, DRAIN and FIN and 0 in IDLE.
REQ-027 The row counter SHALL be 8 bits, shall decrement on accept, and shall never wrap; num_rows=255 SHALL be supported.
REQ-028 The drain counter width SHALL be $clog2(2*N) bits.

Reset
REQ-029 rst=0 SHALL, asynchronously and at any state including mid-transfer, force state IDLE, clear all counters and skew registers, and drive act_ready=0, arr_en=0, arr_in=0, busy=0 and done=0.
REQ-030 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-031 FSM state encoding and the DRAIN length function (2*N-1) SHALL live in shared package sysa_pkg.
REQ-032 A single sub-module, skew_line (parameters DEPTH and DW, with a shift enable), SHALL implement one lane delay and SHALL be instantiated once per lane with DEPTH=k.

Verification
REQ-033 Reset, then start with num_rows=1 and act_data=0x030201 held valid -> arr_in = 0x000001, 0x000200, 0x030000, then zeros; arr_en high 1+5 cycles; done one cycle after the last drain beat.
REQ-034 num_rows=3, rows 0x030201, 0x060504, 0x090807 back-to-back -> second arr_in beat = 0x000204, third = 0x030507; exactly 3 accepts, then 5 zero drain beats, then done.
REQ-035 Same as REQ-034 with act_valid low for 2 cycles after the first accept -> arr_en low 2 cycles, arr_in frozen, beat sequence identical to REQ-034.
REQ-036 start with num_rows=0 -> no arr_en and act_ready never high; done pulses 2 cycles after start; busy high 1 cycle.
REQ-037 rst=0 mid-FEED (after 2 of 3 rows) -> all outputs 0 immediately; a new start with num_rows=1 then behaves as in REQ-033.
REQ-038 start pulsed during DRAIN -> ignored; exactly one done pulse.
